// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - pipelined RV32/RV64 immediate generator with valid/ready register slices
module imm_gen_pipe #(
  parameter int XLEN         = 32,
  parameter int STAGES       = 1,
  parameter int TAG_W        = 5,
  parameter int SUPPORT_ZIMM = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr_31_7,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = XLEN + 1 + TAG_W;

  logic [XLEN-1:0]   dec_imm;
  logic              dec_ill;
  logic              sgn;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_v;
  logic [PW-1:0]     pay   [STAGES];
  logic [PW-1:0]     src_p [STAGES];

  // instr_31_7[k] is instr[k+7]; sgn is instr[31]
  assign sgn = instr_31_7[24];

  always_comb begin
    dec_imm = '0;
    dec_ill = 1'b0;
    case (imm_src)
      3'b000: dec_imm = {{(XLEN-12){sgn}}, instr_31_7[24:13]};
      3'b001: dec_imm = {{(XLEN-12){sgn}}, instr_31_7[24:18], instr_31_7[4:0]};
      3'b010: dec_imm = {{(XLEN-31){sgn}}, instr_31_7[23:5], 12'b0};
      3'b101: dec_imm = {{(XLEN-12){sgn}}, instr_31_7[0], instr_31_7[23:18],
                         instr_31_7[4:1], 1'b0};
      3'b110: dec_imm = {{(XLEN-20){sgn}}, instr_31_7[12:5], instr_31_7[13],
                         instr_31_7[23:14], 1'b0};
      3'b011: begin
        if (SUPPORT_ZIMM != 0) dec_imm = {{(XLEN-5){1'b0}}, instr_31_7[12:8]};
        else                   dec_ill = 1'b1;
      end
      3'b100: begin
        if (XLEN == 32) dec_imm = {{(XLEN-5){1'b0}}, instr_31_7[17:13]};
        else            dec_imm = {{(XLEN-6){1'b0}}, instr_31_7[18:13]};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Ready ripples back from the output: a stage accepts when empty or draining
  always_comb begin
    rdy = '0;
    rdy[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      rdy[i] = !v[i] || rdy[i+1];
    end
  end

  always_comb begin
    src_v    = '0;
    for (int i = 0; i < STAGES; i++) src_p[i] = '0;
    src_v[0] = in_valid;
    src_p[0] = {dec_imm, dec_ill, in_tag};
    for (int i = 1; i < STAGES; i++) begin
      src_v[i] = v[i-1];
      src_p[i] = pay[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) pay[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) v[i] <= src_v[i];
        if (rdy[i] && src_v[i]) pay[i] <= src_p[i];
      end
    end
  end

  assign in_ready                        = rdy[0];
  assign out_valid                       = v[STAGES-1];
  assign {imm_ext, out_illegal, out_tag} = pay[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench: u0 XLEN32/2 stages/zimm, u1 XLEN64/1 stage/no zimm
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid0 = 1'b0, in_valid1 = 1'b0, out_ready = 1'b0;
  logic [24:0] instr = '0;
  logic [2:0]  imm_src = '0;
  logic [4:0]  in_tag = '0;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, ill0, ill1;
  logic [31:0] imm0;
  logic [63:0] imm1;
  logic [4:0]  tag0, tag1;

  int n_cmp = 0, n_err = 0, cyc = 0;
  bit lat0 = 0, lat1 = 0, rnd_bp = 0;

  typedef struct {logic [63:0] imm; logic ill; logic [4:0] tag; int acc;} exp_t;
  typedef struct {logic [31:0] ins; logic [2:0] src; logic [4:0] tag; logic [63:0] exp; bit fixed;} vec_t;
  exp_t q0[$], q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5), .SUPPORT_ZIMM(1)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .instr_31_7(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .imm_ext(imm0),
    .out_illegal(ill0), .out_tag(tag0));

  imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5), .SUPPORT_ZIMM(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .instr_31_7(instr), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .imm_ext(imm1),
    .out_illegal(ill1), .out_tag(tag1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] i, input logic [2:0] s,
                                        input int xl, input bit zm, output logic ill);
    logic [63:0] r;
    r = '0;
    ill = 1'b0;
    case (s)
      3'd0: r = {{52{i[31]}}, i[31:20]};
      3'd1: r = {{52{i[31]}}, i[31:25], i[11:7]};
      3'd2: r = {{32{i[31]}}, i[31:12], 12'h000};
      3'd5: r = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd6: r = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      3'd3: if (zm) r = {59'd0, i[19:15]}; else ill = 1'b1;
      3'd4: r = (xl == 32) ? {59'd0, i[24:20]} : {58'd0, i[25:20]};
      default: ill = 1'b1;
    endcase
    if (xl == 32) r[63:32] = '0;
    return r;
  endfunction

  task automatic send(input int which, input vec_t vv);
    exp_t e;
    logic m_ill;
    logic [63:0] m;
    bit ok;
    instr = vv.ins[31:7];
    imm_src = vv.src;
    in_tag = vv.tag;
    in_valid0 = (which == 0);
    in_valid1 = (which == 1);
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if ((which == 0) ? in_ready0 : in_ready1) begin
        m = model(vv.ins, vv.src, (which == 0) ? 32 : 64, (which == 0), m_ill);
        e.imm = vv.fixed ? vv.exp : m;
        e.ill = m_ill;
        e.tag = vv.tag;
        e.acc = cyc;
        if (which == 0) q0.push_back(e); else q1.push_back(e);
        ok = 1;
      end
    end
    if (!ok) check("send_timeout", 64'(0), 64'(1));
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
    in_valid1 = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 80 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
    #1;
    check("drain_q0", 64'(q0.size()), 64'(0));
    check("drain_q1", 64'(q1.size()), 64'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid0 && out_ready) begin
      if (q0.size() == 0) check("u0_spurious", 64'(1), 64'(0));
      else begin
        e = q0.pop_front();
        check("u0_imm", 64'(imm0), e.imm);
        check("u0_ill", 64'(ill0), 64'(e.ill));
        check("u0_tag", 64'(tag0), 64'(e.tag));
        if (lat0) check("u0_latency", 64'(cyc - e.acc), 64'(2));
      end
    end
    if (rst_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) check("u1_spurious", 64'(1), 64'(0));
      else begin
        e = q1.pop_front();
        check("u1_imm", imm1, e.imm);
        check("u1_ill", 64'(ill1), 64'(e.ill));
        check("u1_tag", 64'(tag1), 64'(e.tag));
        if (lat1) check("u1_latency", 64'(cyc - e.acc), 64'(1));
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = ($urandom_range(3) != 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t v0[8] = '{
    '{32'hFFF00093, 3'b000, 5'd1, 64'hFFFF_FFFF, 1'b1},
    '{32'hFE000EE3, 3'b101, 5'd2, 64'hFFFF_FFFC, 1'b1},
    '{32'h000FD073, 3'b011, 5'd3, 64'h1F,        1'b1},
    '{32'h12345678, 3'b111, 5'd4, 64'h0,         1'b1},
    '{32'h03F09093, 3'b100, 5'd5, 64'h1F,        1'b1},
    '{32'hFE112E23, 3'b001, 5'd6, 64'hFFFF_FFFC, 1'b1},
    '{32'h800000B7, 3'b010, 5'd7, 64'h8000_0000, 1'b1},
    '{32'hFFDFF0EF, 3'b110, 5'd8, 64'hFFFF_FFFC, 1'b1}};

  vec_t v1[6] = '{
    '{32'h800000B7, 3'b010, 5'd9,  64'hFFFF_FFFF_8000_0000, 1'b1},
    '{32'h000FD073, 3'b011, 5'd10, 64'h0,                   1'b1},
    '{32'h03F09093, 3'b100, 5'd11, 64'h3F,                  1'b1},
    '{32'hFE000EE3, 3'b101, 5'd12, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1},
    '{32'hFFF00093, 3'b000, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1},
    '{32'h12345678, 3'b111, 5'd14, 64'h0,                   1'b1}};

  initial begin
    vec_t a, b, c;
    int start;

    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready0", 64'(in_ready0), 64'(1));
    check("rst_out_valid0", 64'(out_valid0), 64'(0));
    check("rst_imm0", 64'(imm0), 64'(0));
    check("rst_ill0", 64'(ill0), 64'(0));
    check("rst_tag0", 64'(tag0), 64'(0));
    check("rst_in_ready1", 64'(in_ready1), 64'(1));
    check("rst_out_valid1", 64'(out_valid1), 64'(0));
    check("rst_imm1", imm1, 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed formats, back-to-back with no backpressure
    out_ready = 1'b1;
    lat0 = 1;
    start = cyc;
    foreach (v0[i]) send(0, v0[i]);
    check("u0_throughput", 64'(cyc - start), 64'(8));
    drain();
    lat0 = 0;

    // backpressure: two beats fill u0, third waits
    a = '{32'hFFF00093, 3'b000, 5'd17, 64'hFFFF_FFFF, 1'b1};
    b = '{32'hFE000EE3, 3'b101, 5'd18, 64'hFFFF_FFFC, 1'b1};
    c = '{32'h000FD073, 3'b011, 5'd19, 64'h1F,        1'b1};
    out_ready = 1'b0;
    send(0, a);
    send(0, b);
    instr = c.ins[31:7];
    imm_src = c.src;
    in_tag = c.tag;
    in_valid0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready0), 64'(0));
      check("bp_out_valid", 64'(out_valid0), 64'(1));
      check("bp_imm_stable", 64'(imm0), 64'hFFFF_FFFF);
      check("bp_tag_stable", 64'(tag0), 64'(17));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(0, c);
    drain();

    // asynchronous reset with two beats in flight
    out_ready = 1'b0;
    send(0, '{32'h12345678, 3'b111, 5'd21, 64'h0, 1'b1});
    send(0, '{32'hFFF00093, 3'b000, 5'd22, 64'hFFFF_FFFF, 1'b1});
    #2;
    check("pre_rst_ill", 64'(ill0), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid0), 64'(0));
    check("mid_rst_imm", 64'(imm0), 64'(0));
    check("mid_rst_ill", 64'(ill0), 64'(0));
    check("mid_rst_tag", 64'(tag0), 64'(0));
    check("mid_rst_in_ready", 64'(in_ready0), 64'(1));
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    lat0 = 1;
    send(0, '{32'hFE112E23, 3'b001, 5'd23, 64'hFFFF_FFFC, 1'b1});
    drain();
    lat0 = 0;

    // random traffic with random backpressure
    rnd_bp = 1;
    for (int k = 0; k < 40; k++)
      send(0, '{$urandom, 3'($urandom_range(7)), 5'($urandom_range(31)), 64'h0, 1'b0});
    for (int k = 0; k < 20; k++)
      send(1, '{$urandom, 3'($urandom_range(7)), 5'($urandom_range(31)), 64'h0, 1'b0});
    rnd_bp = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // RV64 single-stage instance, no zimm support
    lat1 = 1;
    foreach (v1[i]) send(1, v1[i]);
    drain();
    lat1 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
